// File: rtl/axi_rd_arbiter.sv
// Two-master to one-slave AXI4 read arbiter (AR/R channels).
// Round-robin grant, single burst in flight, master tag in ARID MSB.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 8
) (
  input  logic              uncoreclk,
  input  logic              uncorerstn,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [ID_W-1:0]   s0_arid,
  input  logic [7:0]        s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [ID_W-1:0]   s0_rid,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [ID_W-1:0]   s1_arid,
  input  logic [7:0]        s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [ID_W-1:0]   s1_rid,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [ID_W:0]     m_arid,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [ID_W:0]     m_rid,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t state;
  logic   grant;
  logic   rr_ptr;
  logic   win;
  logic   accept;
  logic   in_data;
  logic   r_done;
  logic   unused_rid_msb;

  always_comb begin
    win = rr_ptr;
    unique case (1'b1)
      (s0_arvalid & ~s1_arvalid): win = 1'b0;
      (s1_arvalid & ~s0_arvalid): win = 1'b1;
      default:                    win = rr_ptr;
    endcase
  end

  // Ready is gated by reset so nothing handshakes while held in reset.
  assign accept = uncorerstn & (state == IDLE)
                & (s0_arvalid | s1_arvalid);
  assign s0_arready = accept & ~win;
  assign s1_arready = accept & win;

  assign in_data = (state == DATA);
  assign busy    = (state != IDLE);

  assign s0_rvalid = in_data & ~grant & m_rvalid;
  assign s1_rvalid = in_data & grant & m_rvalid;
  assign m_rready  = in_data
                   & (grant ? s1_rready : s0_rready);
  assign r_done    = in_data & m_rvalid
                   & m_rready & m_rlast;

  assign s0_rdata = m_rdata;
  assign s0_rid   = m_rid[ID_W-1:0];
  assign s0_rresp = m_rresp;
  assign s0_rlast = m_rlast;
  assign s1_rdata = m_rdata;
  assign s1_rid   = m_rid[ID_W-1:0];
  assign s1_rresp = m_rresp;
  assign s1_rlast = m_rlast;

  // Routing follows the grant register, not the returned tag.
  assign unused_rid_msb = m_rid[ID_W];

  always_ff @(posedge uncoreclk or negedge uncorerstn) begin
    if (!uncorerstn) begin
      state     <= IDLE;
      grant     <= 1'b0;
      rr_ptr    <= 1'b0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arid    <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant     <= win;
            m_arvalid <= 1'b1;
            m_araddr  <= win ? s1_araddr : s0_araddr;
            m_arid    <= {win, win ? s1_arid : s0_arid};
            m_arlen   <= win ? s1_arlen : s0_arlen;
            m_arsize  <= win ? s1_arsize : s0_arsize;
            m_arburst <= win ? s1_arburst : s0_arburst;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (r_done) begin
            rr_ptr <= ~grant;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed + randomized bench for axi_rd_arbiter.
// Reference keeps only a "who went last" pointer and per-burst expectations.
module tb_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 8;

  logic          uncoreclk = 1'b0;
  logic          uncorerstn = 1'b1;
  logic          s0_arvalid, s0_arready;
  logic [AW-1:0] s0_araddr;
  logic [IW-1:0] s0_arid;
  logic [7:0]    s0_arlen;
  logic [2:0]    s0_arsize;
  logic [1:0]    s0_arburst;
  logic          s0_rvalid, s0_rready;
  logic [DW-1:0] s0_rdata;
  logic [IW-1:0] s0_rid;
  logic [1:0]    s0_rresp;
  logic          s0_rlast;
  logic          s1_arvalid, s1_arready;
  logic [AW-1:0] s1_araddr;
  logic [IW-1:0] s1_arid;
  logic [7:0]    s1_arlen;
  logic [2:0]    s1_arsize;
  logic [1:0]    s1_arburst;
  logic          s1_rvalid, s1_rready;
  logic [DW-1:0] s1_rdata;
  logic [IW-1:0] s1_rid;
  logic [1:0]    s1_rresp;
  logic          s1_rlast;
  logic          m_arvalid, m_arready;
  logic [AW-1:0] m_araddr;
  logic [IW:0]   m_arid;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic          m_rvalid, m_rready;
  logic [DW-1:0] m_rdata;
  logic [IW:0]   m_rid;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic          busy;

  int total = 0;
  int bad = 0;
  bit rr_m = 1'b0;
  bit grants[$];

  axi_rd_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)
  ) dut (
    .uncoreclk(uncoreclk), .uncorerstn(uncorerstn),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_araddr(s0_araddr), .s0_arid(s0_arid),
    .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
    .s0_arburst(s0_arburst),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s0_rdata(s0_rdata), .s0_rid(s0_rid),
    .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_araddr(s1_araddr), .s1_arid(s1_arid),
    .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
    .s1_arburst(s1_arburst),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .s1_rdata(s1_rdata), .s1_rid(s1_rid),
    .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rid(m_rid),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .busy(busy)
  );

  always #5 uncoreclk = ~uncoreclk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge uncoreclk);
    @(negedge uncoreclk);
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_ar0"}, s0_arready, 0);
    chk({tag, "_ar1"}, s1_arready, 0);
    chk({tag, "_rv0"}, s0_rvalid, 0);
    chk({tag, "_rv1"}, s1_rvalid, 0);
    chk({tag, "_marv"}, m_arvalid, 0);
    chk({tag, "_mrr"}, m_rready, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic zero_in();
    s0_arvalid = 0; s0_araddr = 0; s0_arid = 0;
    s0_arlen = 0; s0_arsize = 0; s0_arburst = 0;
    s0_rready = 0;
    s1_arvalid = 0; s1_araddr = 0; s1_arid = 0;
    s1_arlen = 0; s1_arsize = 0; s1_arburst = 0;
    s1_rready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0;
    m_rid = 0; m_rresp = 0; m_rlast = 0;
  endtask

  // One complete arbitration + burst; entered and left just after a negedge.
  task automatic round(input bit r0, input bit r1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [7:0] i0, input logic [7:0] i1,
                       input logic [7:0] l0, input logic [7:0] l1,
                       input int arwait, input int stall_first,
                       input bit rnd_stall);
    bit w;
    bit rr;
    bit msb;
    int st;
    logic [31:0] a;
    logic [7:0] id, len;
    logic [2:0] sz;
    logic [1:0] bu, rs;
    logic [63:0] d;
    w = (r0 && r1) ? rr_m : r1;
    sz = 3'($urandom_range(0, 3));
    bu = 2'($urandom_range(0, 2));
    s0_arvalid = r0; s0_araddr = a0; s0_arid = i0;
    s0_arlen = l0; s0_arsize = sz; s0_arburst = bu;
    s1_arvalid = r1; s1_araddr = a1; s1_arid = i1;
    s1_arlen = l1; s1_arsize = sz; s1_arburst = bu;
    #1;
    chk("grant_ar0", s0_arready, !w);
    chk("grant_ar1", s1_arready, w);
    a = w ? a1 : a0;
    id = w ? i1 : i0;
    len = w ? l1 : l0;
    grants.push_back(w);
    step();
    if (w) s1_arvalid = 0;
    else s0_arvalid = 0;
    for (int c = 0; c <= arwait; c++) begin
      #1;
      chk("addr_valid", m_arvalid, 1);
      chk("addr_addr", m_araddr, a);
      chk("addr_id", m_arid, {w, id});
      chk("addr_len", m_arlen, len);
      chk("addr_size", m_arsize, sz);
      chk("addr_burst", m_arburst, bu);
      chk("addr_ar0", s0_arready, 0);
      chk("addr_ar1", s1_arready, 0);
      chk("addr_busy", busy, 1);
      if (c == arwait) m_arready = 1;
      step();
    end
    m_arready = 0;
    #1;
    chk("data_arv", m_arvalid, 0);
    chk("data_busy", busy, 1);
    for (int b = 0; b <= int'(len); b++) begin
      d = {$urandom, $urandom};
      rs = 2'($urandom_range(0, 3));
      msb = 1'($urandom_range(0, 1));
      m_rvalid = 1; m_rdata = d; m_rresp = rs;
      m_rlast = (b == int'(len));
      m_rid = {msb, id};
      st = (b == 0) ? stall_first : 0;
      for (int k = 0; k < 16; k++) begin
        rr = (k >= st) &&
             !(rnd_stall && k < 8 &&
               $urandom_range(0, 2) == 0);
        if (w) begin
          s1_rready = rr;
          s0_rready = 1'($urandom_range(0, 1));
        end else begin
          s0_rready = rr;
          s1_rready = 1'($urandom_range(0, 1));
        end
        #1;
        chk("r_own_v", w ? s1_rvalid : s0_rvalid, 1);
        chk("r_oth_v", w ? s0_rvalid : s1_rvalid, 0);
        chk("r_data", w ? s1_rdata : s0_rdata, d);
        chk("r_id", w ? s1_rid : s0_rid, id);
        chk("r_resp", w ? s1_rresp : s0_rresp, rs);
        chk("r_last", w ? s1_rlast : s0_rlast,
            b == int'(len));
        chk("r_mready", m_rready, rr);
        step();
        if (rr) break;
      end
    end
    m_rvalid = 0; m_rlast = 0;
    s0_rready = 0; s1_rready = 0;
    rr_m = ~w;
    #1;
    chk("end_busy", busy, 0);
  endtask

  initial begin
    bit r0, r1;
    zero_in();
    #2 uncorerstn = 0;
    repeat (3) @(negedge uncoreclk);
    #1 quiet("rst");
    @(negedge uncoreclk);
    uncorerstn = 1;
    for (int c = 0; c < 10; c++) begin
      #1 quiet("idle");
      step();
    end

    // Master 1 alone, 4-beat burst.
    round(0, 1, 32'h0, 32'h8000_1000, 8'h00, 8'h05,
          8'd0, 8'd3, 0, 0, 0);
    chk("t2_grant", grants[$], 1);

    // Simultaneous request after the solo burst: rr points back at 0.
    round(1, 1, 32'h100, 32'h200, 8'h11, 8'h22,
          8'd1, 8'd1, 0, 0, 0);
    round(0, 1, 32'h100, 32'h200, 8'h11, 8'h22,
          8'd1, 8'd1, 0, 0, 0);
    chk("t3_first", grants[1], 0);
    chk("t3_second", grants[2], 1);

    // Continuous contention: strict alternation.
    for (int n = 0; n < 6; n++) begin
      round(1, 1, 32'h1000 + n, 32'h2000 + n,
            8'(n), 8'(8'h40 + n), 8'd0, 8'd0, 0, 0, 0);
      chk("t4_alt", grants[$], n[0]);
    end

    // Address stall then R backpressure on master 0.
    round(1, 0, 32'hdead_beec, 32'h0, 8'h7e, 8'h00,
          8'd2, 8'd0, 5, 3, 0);

    // Reset in the middle of a 4-beat burst (rr currently 1).
    s0_arvalid = 1; s0_araddr = 32'h4000; s0_arid = 8'h33;
    s0_arlen = 8'd3; s0_arsize = 3; s0_arburst = 1;
    step();
    s0_arvalid = 0; m_arready = 1;
    step();
    m_arready = 0;
    m_rvalid = 1; m_rdata = 64'h1; m_rid = 9'h033;
    s0_rready = 1;
    #1 chk("t6_b1", s0_rvalid, 1);
    step();
    m_rdata = 64'h2; s1_arvalid = 1;
    #1 chk("t6_b2", s0_rvalid, 1);
    uncorerstn = 0;
    #1 quiet("t6_rst");
    chk("t6_arid", m_arid, 0);
    chk("t6_araddr", m_araddr, 0);
    step();
    zero_in();
    uncorerstn = 1;
    rr_m = 0;
    #1 quiet("t6_rel");
    round(1, 1, 32'h10, 32'h20, 8'h01, 8'h02,
          8'd1, 8'd2, 0, 0, 0);
    chk("t6_rr0", grants[$], 0);
    round(0, 1, 32'h10, 32'h20, 8'h01, 8'h02,
          8'd1, 8'd2, 0, 0, 0);
    chk("t6_s1", grants[$], 1);

    // Randomized traffic.
    for (int n = 0; n < 25; n++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      round(r0, r1, $urandom, $urandom,
            8'($urandom), 8'($urandom),
            8'($urandom_range(0, 3)),
            8'($urandom_range(0, 3)),
            $urandom_range(0, 2),
            $urandom_range(0, 2), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-master to one-slave AXI4 read-channel arbiter (AR/R only) in the uncore clock domain.
- Shares the single memory read port between the core memory master (master 0) and the DMA/secondary master (master 1).
- Round-robin, one burst in flight at a time. The source master is tagged in the MSB of the outgoing ARID.
- Write channels are out of scope; a sibling write arbiter owns them.

Parameters:
ADDR_W, 32, address width on all ports
DATA_W, 64, read data width on all ports
ID_W, 8, master-side ID width; slave-side ID is ID_W+1

Ports:
uncoreclk  in  1  clock
uncorerstn  in  1  asynchronous active-low reset
s0_arvalid/s0_arready  in/out  1/1  master 0 AR handshake
s0_araddr/s0_arid/s0_arlen/s0_arsize/s0_arburst  in  ADDR_W/ID_W/8/3/2  master 0 AR payload
s0_rvalid/s0_rready  out/in  1/1  master 0 R handshake
s0_rdata/s0_rid/s0_rresp/s0_rlast  out  DATA_W/ID_W/2/1  master 0 R payload
s1_* (same set as s0_*)  master 1, identical widths and directions
m_arvalid/m_arready  out/in  1/1  slave AR handshake
m_araddr/m_arid/m_arlen/m_arsize/m_arburst  out  ADDR_W/ID_W+1/8/3/2  slave AR payload
m_rvalid/m_rready  in/out  1/1  slave R handshake
m_rdata/m_rid/m_rresp/m_rlast  in  DATA_W/ID_W+1/2/1  slave R payload
busy  out  1  high when state is not IDLE

Behaviour:
- Reset (async assert on uncorerstn low, released synchronously to uncoreclk):
  - state=IDLE, rr_ptr=0 (master 0 preferred).
  - All ready/valid outputs 0; payload registers 0; busy=0.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Winner: if only one sX_arvalid is high, that master. If both are high, master rr_ptr.
  - The winner's sX_arready=1 combinationally in this cycle; the loser's arready=0.
  - On the accept edge: latch payload into AR registers; m_arid = {grant, sX_arid}; grant reg = winner; go to ADDR.
  - No arvalid: stay in IDLE, all arready=0.
- ADDR:
  - m_arvalid=1 from registers; payload stable until handshake.
  - m_arready=1 -> DATA next cycle. Otherwise hold (no timeout).
  - Both sX_arready=0.
- DATA:
  - Route R to the granted master: s{g}_rvalid=m_rvalid, m_rready=s{g}_rready, s{g}_rdata/rresp/rlast = m_*, s{g}_rid = m_rid[ID_W-1:0].
  - Non-granted master: rvalid=0.
  - Routing is by the grant register. m_rid MSB is ignored for routing.
  - Beat with m_rvalid & m_rready & m_rlast -> IDLE next cycle; rr_ptr = ~grant.
  - Beats without rlast: stay in DATA; no beat counting.
  - A master may already be asserting arvalid; it is not accepted until IDLE.
- Latency:
  - AR accept at cycle n -> m_arvalid at n+1.
  - Last R beat at cycle k -> earliest next AR accept at k+1 (IDLE cycle).
- busy = (state != IDLE).
- All R-path signals are combinational pass-through; no data buffering.
- rr_ptr updates only on burst completion, so each master gets at most one consecutive burst while the other requests.
- Reset mid-burst: FSM returns to IDLE immediately. The in-flight burst is abandoned; the subsystem reset owner resets the slave too.
- Payload arithmetic: none. Widths pass through except the ID extension.

Test Plan:
1. Reset held, then released with no traffic -> all arready/rvalid/m_arvalid=0, busy=0 for 10 cycles.
2. Only master 1: s1 araddr=0x8000_1000, arid=0x05, arlen=3; slave returns 4 beats -> m_arid=0x105, m_arlen=3; s1 gets 4 beats with rid=0x05, rlast on beat 4; s0_rvalid stays 0.
3. Both request in the same cycle after reset -> master 0 is granted first (m_arid MSB=0). After its rlast, master 1 is granted (MSB=1) in the first IDLE cycle.
4. Both request continuously, arlen=0 each, 6 bursts -> grants alternate 0,1,0,1,0,1; each R beat is delivered only to its owner.
5. m_arready held low 5 cycles in ADDR -> m_arvalid and payload stable for 5 cycles, both sX_arready=0. Then m_rready backpressure via s0_rready=0 -> m_rready=0 and data held.
6. Assert uncorerstn low mid-DATA (beat 2 of 4) -> outputs 0 asynchronously, state=IDLE, rr_ptr=0. After release, a new s1 request is accepted normally.
